// File: rtl/alu1_pkg.sv
// Shared definitions for the one-bit ALU slice: the operation encoding and a
// couple of helpers used by the result mux.
package alu1_pkg;

    // Operation select, three bits wide
    typedef logic [2:0] alu_op_t;

    localparam alu_op_t OP_AND   = 3'b000;
    localparam alu_op_t OP_SLT   = 3'b001;
    localparam alu_op_t OP_OR    = 3'b010;
    localparam alu_op_t OP_XOR   = 3'b011;
    localparam alu_op_t OP_ADD   = 3'b100;
    localparam alu_op_t OP_NOR   = 3'b101;
    localparam alu_op_t OP_NAND  = 3'b110;
    localparam alu_op_t OP_PASSA = 3'b111;

    // Conditionally invert an operand bit
    function automatic logic cond_invert(input logic bit_in, input logic invert);
        return bit_in ^ invert;
    endfunction

    // True when the selected operation depends on the adder sum
    function automatic logic op_uses_adder(input alu_op_t op_sel);
        return (op_sel == OP_ADD);
    endfunction

endpackage

// File: rtl/alu1_full_adder.sv
// One-bit full adder used by the ALU slice. Purely combinational.
module alu1_full_adder (
    input  logic i_aa,
    input  logic i_bb,
    input  logic i_cin,
    output logic o_sum,
    output logic o_carry
);

    // Sum and majority carry
    always_comb begin
        o_sum   = i_aa ^ i_bb ^ i_cin;
        o_carry = (i_aa & i_bb) | (i_aa & i_cin) | (i_bb & i_cin);
    end

endmodule

// File: rtl/alu1_slice.sv
// One-bit ALU slice: conditioned operands, full adder, op-selected result mux
// and registered result/carry. Sixteen of these ripple-chain into a 16-bit ALU.
// Optional overflow outputs are enabled by defining ALU1_OVF_EN.
module alu1_slice
    import alu1_pkg::*;
#(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic       a,
    input  logic       b,
    input  logic       cin,
    input  logic       a_invert,
    input  logic       b_invert,
    input  logic       less,
    input  logic [2:0] op,
    output logic       carry_out,
    output logic       set,
    output logic       result_q,
`ifdef ALU1_OVF_EN
    output logic       carry_q,
    output logic       overflow,
    output logic       overflow_q
`else
    output logic       carry_q
`endif
);

    logic    w_aa;
    logic    w_bb;
    logic    w_sum;
    logic    w_carry;
    logic    w_res_d;
    alu_op_t w_op;

    logic    r_result;
    logic    r_carry;

    assign w_op = alu_op_t'(op);

    // Operand conditioning ahead of both the adder and the logic ops
    always_comb begin
        w_aa = cond_invert(a, a_invert);
        w_bb = cond_invert(b, b_invert);
    end

    alu1_full_adder u_full_adder (
        .i_aa    (w_aa),
        .i_bb    (w_bb),
        .i_cin   (cin),
        .o_sum   (w_sum),
        .o_carry (w_carry)
    );

    // set comes straight from the adder, never from the mux, so feeding the MSB
    // set back into bit 0's less cannot form a combinational loop.
    assign carry_out = w_carry;
    assign set       = w_sum;

    // Result mux; less only reaches the output under SLT
    always_comb begin
        w_res_d = 1'b0;
        case (w_op)
            OP_AND:   w_res_d = w_aa & w_bb;
            OP_SLT:   w_res_d = less;
            OP_OR:    w_res_d = w_aa | w_bb;
            OP_XOR:   w_res_d = w_aa ^ w_bb;
            OP_ADD:   w_res_d = op_uses_adder(w_op) & w_sum;
            OP_NOR:   w_res_d = ~(w_aa | w_bb);
            OP_NAND:  w_res_d = ~(w_aa & w_bb);
            OP_PASSA: w_res_d = w_aa;
            default:  w_res_d = 1'b0;
        endcase
    end

    // Output registers: async reset dominates, otherwise load when enabled
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_result <= RESET_VAL;
            r_carry  <= RESET_VAL;
        end else if (en) begin
            r_result <= w_res_d;
            r_carry  <= w_carry;
        end
    end

    assign result_q = r_result;
    assign carry_q  = r_carry;

`ifdef ALU1_OVF_EN
    logic w_overflow;
    logic r_overflow;

    // Signed overflow is carry-in vs carry-out disagreement; only the MSB slice
    // gives a meaningful value.
    assign w_overflow = cin ^ w_carry;
    assign overflow   = w_overflow;

    // Overflow register follows the same enable/reset rules, resetting to 0
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_overflow <= 1'b0;
        end else if (en) begin
            r_overflow <= w_overflow;
        end
    end

    assign overflow_q = r_overflow;
`endif

endmodule

// File: tb/tb_alu1_slice.sv
// Self-checking bench for alu1_slice: directed scenarios plus a randomized run
// compared against an arithmetic reference model.
module tb_alu1_slice;

    logic       clk;
    logic       reset;
    logic       en;
    logic       a;
    logic       b;
    logic       cin;
    logic       a_invert;
    logic       b_invert;
    logic       less;
    logic [2:0] op;
    logic       carry_out;
    logic       set;
    logic       result_q;
    logic       carry_q;
`ifdef ALU1_OVF_EN
    logic       overflow;
    logic       overflow_q;
`endif

    int checks;
    int failures;

    // Expected register contents tracked by the bench
    logic exp_res;
    logic exp_carry;
    logic exp_ovf;

    alu1_slice #(
        .RESET_VAL (1'b0)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .a          (a),
        .b          (b),
        .cin        (cin),
        .a_invert   (a_invert),
        .b_invert   (b_invert),
        .less       (less),
        .op         (op),
        .carry_out  (carry_out),
        .set        (set),
        .result_q   (result_q),
`ifdef ALU1_OVF_EN
        .carry_q    (carry_q),
        .overflow   (overflow),
        .overflow_q (overflow_q)
`else
        .carry_q    (carry_q)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: operands as integers 0/1, adder by plain addition
    function automatic void model(input logic ma, input logic mb, input logic mcin,
                                  input logic mai, input logic mbi, input logic mless,
                                  input logic [2:0] mop, output logic mres,
                                  output logic msum, output logic mcarry,
                                  output logic movf);
        int x;
        int y;
        int total;
        x = mai ? 1 - int'(ma) : int'(ma);
        y = mbi ? 1 - int'(mb) : int'(mb);
        total = x + y + int'(mcin);
        msum = (total % 2) == 1;
        mcarry = total >= 2;
        movf = mcin != mcarry;
        case (mop)
            3'd0: mres = (x * y) == 1;
            3'd1: mres = mless;
            3'd2: mres = (x + y) > 0;
            3'd3: mres = (x + y) == 1;
            3'd4: mres = msum;
            3'd5: mres = (x + y) == 0;
            3'd6: mres = (x * y) != 1;
            default: mres = x == 1;
        endcase
    endfunction

    // Apply inputs away from the rising edge and update the expected next state
    task automatic drive(input logic ia, input logic ib, input logic icin,
                         input logic iai, input logic ibi, input logic iless,
                         input logic ien, input logic [2:0] iop);
        logic r, s, c, o;
        @(negedge clk);
        a = ia; b = ib; cin = icin; a_invert = iai; b_invert = ibi;
        less = iless; en = ien; op = iop;
        #1;
        model(ia, ib, icin, iai, ibi, iless, iop, r, s, c, o);
        if (ien) begin
            exp_res = r;
            exp_carry = c;
            exp_ovf = o;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(1, 0, 0, 0, 0, 1, 1, 3'b111);
        tick();
        tick();
        checks++;
        if (result_q !== 1'b0) begin
            failures++;
            $display("FAIL reset_result got=%b exp=0", result_q);
        end
        checks++;
        if (carry_q !== 1'b0) begin
            failures++;
            $display("FAIL reset_carry got=%b exp=0", carry_q);
        end
`ifdef ALU1_OVF_EN
        checks++;
        if (overflow_q !== 1'b0) begin
            failures++;
            $display("FAIL reset_ovf got=%b exp=0", overflow_q);
        end
`endif
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_and();
        drive(1, 1, 0, 0, 0, 0, 1, 3'b000);
        checks++;
        if (carry_out !== 1'b1) begin
            failures++;
            $display("FAIL and_carry_comb got=%b exp=1", carry_out);
        end
        tick();
        checks++;
        if (result_q !== 1'b1) begin
            failures++;
            $display("FAIL and_11 got=%b exp=1", result_q);
        end
        drive(1, 0, 0, 0, 0, 0, 1, 3'b000);
        tick();
        checks++;
        if (result_q !== 1'b0) begin
            failures++;
            $display("FAIL and_10 got=%b exp=0", result_q);
        end
    endtask

    task automatic test_add();
        drive(1, 1, 1, 0, 0, 0, 1, 3'b100);
        checks++;
        if ({set, carry_out} !== 2'b11) begin
            failures++;
            $display("FAIL add_111_comb got=%b%b exp=11", set, carry_out);
        end
        tick();
        checks++;
        if (result_q !== 1'b1) begin
            failures++;
            $display("FAIL add_111_reg got=%b exp=1", result_q);
        end
        drive(1, 0, 0, 0, 0, 0, 1, 3'b100);
        tick();
        checks++;
        if ({result_q, carry_q} !== 2'b10) begin
            failures++;
            $display("FAIL add_100_reg got=%b%b exp=10", result_q, carry_q);
        end
    endtask

    task automatic test_sub_slt();
        drive(0, 1, 1, 0, 1, 0, 1, 3'b100);
        checks++;
        if ({set, carry_out} !== 2'b10) begin
            failures++;
            $display("FAIL sub_comb got=%b%b exp=10", set, carry_out);
        end
        drive(0, 1, 1, 0, 1, 1, 1, 3'b001);
        tick();
        checks++;
        if (result_q !== 1'b1) begin
            failures++;
            $display("FAIL slt_less1 got=%b exp=1", result_q);
        end
        drive(0, 1, 1, 0, 1, 0, 1, 3'b001);
        tick();
        checks++;
        if (result_q !== 1'b0) begin
            failures++;
            $display("FAIL slt_less0 got=%b exp=0", result_q);
        end
    endtask

    task automatic test_invert();
        drive(0, 0, 0, 1, 0, 0, 1, 3'b000);
        tick();
        checks++;
        if (result_q !== 1'b0) begin
            failures++;
            $display("FAIL inv_and got=%b exp=0", result_q);
        end
        drive(0, 0, 0, 0, 0, 0, 1, 3'b101);
        tick();
        checks++;
        if (result_q !== 1'b1) begin
            failures++;
            $display("FAIL nor_00 got=%b exp=1", result_q);
        end
        drive(1, 0, 0, 0, 0, 0, 1, 3'b011);
        tick();
        checks++;
        if (result_q !== 1'b1) begin
            failures++;
            $display("FAIL xor_10 got=%b exp=1", result_q);
        end
    endtask

    task automatic test_enable_hold();
        drive(1, 1, 1, 0, 0, 0, 1, 3'b100);
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(logic'(i), 0, 0, 0, 0, 0, 0, 3'b000);
            tick();
            checks++;
            if ({result_q, carry_q} !== 2'b11) begin
                failures++;
                $display("FAIL en_hold_%0d got=%b%b exp=11", i, result_q, carry_q);
            end
        end
    endtask

    task automatic test_reset_midcycle();
        drive(1, 1, 1, 0, 0, 0, 1, 3'b100);
        tick();
        #2;
        reset = 1'b1;
        #1;
        exp_res = 1'b0;
        exp_carry = 1'b0;
        exp_ovf = 1'b0;
        checks++;
        if ({result_q, carry_q} !== 2'b00) begin
            failures++;
            $display("FAIL reset_async got=%b%b exp=00", result_q, carry_q);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

`ifdef ALU1_OVF_EN
    task automatic test_overflow();
        drive(0, 0, 1, 0, 0, 0, 1, 3'b100);
        checks++;
        if ({carry_out, overflow} !== 2'b01) begin
            failures++;
            $display("FAIL ovf_cin got=%b%b exp=01", carry_out, overflow);
        end
        tick();
        checks++;
        if (overflow_q !== 1'b1) begin
            failures++;
            $display("FAIL ovf_q got=%b exp=1", overflow_q);
        end
        drive(1, 1, 0, 0, 0, 0, 1, 3'b100);
        checks++;
        if (overflow !== 1'b1) begin
            failures++;
            $display("FAIL ovf_carry got=%b exp=1", overflow);
        end
    endtask
`endif

    task automatic test_random();
        logic r, s, c, o;
        for (int i = 0; i < 300; i++) begin
            drive(logic'($urandom_range(1)), logic'($urandom_range(1)),
                  logic'($urandom_range(1)), logic'($urandom_range(1)),
                  logic'($urandom_range(1)), logic'($urandom_range(1)),
                  logic'($urandom_range(3) != 0), 3'($urandom_range(7)));
            model(a, b, cin, a_invert, b_invert, less, op, r, s, c, o);
            checks++;
            if ({set, carry_out} !== {s, c}) begin
                failures++;
                $display("FAIL rand_comb_%0d got=%b%b exp=%b%b", i, set, carry_out, s, c);
            end
`ifdef ALU1_OVF_EN
            checks++;
            if (overflow !== o) begin
                failures++;
                $display("FAIL rand_ovf_%0d got=%b exp=%b", i, overflow, o);
            end
`endif
            tick();
            checks++;
            if ({result_q, carry_q} !== {exp_res, exp_carry}) begin
                failures++;
                $display("FAIL rand_reg_%0d got=%b%b exp=%b%b", i, result_q, carry_q,
                         exp_res, exp_carry);
            end
`ifdef ALU1_OVF_EN
            checks++;
            if (overflow_q !== exp_ovf) begin
                failures++;
                $display("FAIL rand_ovfq_%0d got=%b exp=%b", i, overflow_q, exp_ovf);
            end
`endif
            if ($urandom_range(15) == 0) begin
                reset = 1'b1;
                #1;
                exp_res = 1'b0;
                exp_carry = 1'b0;
                exp_ovf = 1'b0;
                checks++;
                if ({result_q, carry_q} !== 2'b00) begin
                    failures++;
                    $display("FAIL rand_reset_%0d got=%b%b exp=00", i, result_q, carry_q);
                end
                #1;
                reset = 1'b0;
            end
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        exp_res = 1'b0;
        exp_carry = 1'b0;
        exp_ovf = 1'b0;
        reset = 1'b1;
        en = 1'b0;
        a = 1'b0;
        b = 1'b0;
        cin = 1'b0;
        a_invert = 1'b0;
        b_invert = 1'b0;
        less = 1'b0;
        op = 3'b000;
        test_reset();
        test_and();
        test_add();
        test_sub_slt();
        test_invert();
        test_enable_hold();
        test_reset_midcycle();
`ifdef ALU1_OVF_EN
        test_overflow();
`endif
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu1_slice.md
Name: alu1_slice

Overview:
- One-bit ALU slice; 16 instances ripple-chained form the 16-bit datapath ALU.
- Computes AND/OR/XOR/NOR/ADD/SLT on one bit pair with optional A/B inversion.
- Ripple carry and set outputs are combinational for chaining.
- The result bit is registered, giving a one-cycle latency.

Parameters:
- RESET_VAL, 1'b0, value loaded into result_q and carry_q on reset.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- en  input  1  load enable for the output registers.
- a  input  1  operand A bit.
- b  input  1  operand B bit.
- cin  input  1  carry in. Bit 0 takes b_invert, so subtract = invert + 1.
- a_invert  input  1  use ~a in place of a.
- b_invert  input  1  use ~b in place of b (b_negate).
- less  input  1  SLT source bit. Bit 0 takes the MSB slice's set; all other bits take 0.
- op  input  3  operation select.
- carry_out  output  1  combinational adder carry, ripple to the next slice.
- set  output  1  combinational raw adder sum bit; used by the MSB slice to drive bit 0's less.
- result_q  output  1  registered selected result.
- carry_q  output  1  registered carry_out.

Behaviour:
- Operand conditioning: aa = a ^ a_invert; bb = b ^ b_invert.
- Adder: sum = aa ^ bb ^ cin; carry_out = (aa & bb) | (aa & cin) | (bb & cin).
- set = sum. carry_out and set are purely combinational, with no dependence on clk or en.
- Op encoding:
  - 000 AND: aa & bb.
  - 001 SLT: less.
  - 010 OR: aa | bb.
  - 011 XOR: aa ^ bb.
  - 100 ADD: sum.
  - 101 NOR: ~(aa | bb).
  - 110 NAND: ~(aa & bb).
  - 111 PASS_A: aa.
- Combinational selected value res_d is chosen by op.
- Registers:
  - On the rising edge of clk with en = 1: result_q <= res_d and carry_q <= carry_out.
  - With en = 0: both registers hold.
- Latency is 1 cycle from inputs to result_q/carry_q.
- Reset:
  - Asserting reset immediately sets result_q and carry_q to RESET_VAL, regardless of clk or en.
  - Reset dominates a simultaneous clock edge.
  - After deassertion, the first rising edge with en = 1 loads normally.
- Subtract is op = 100 with b_invert = 1 and cin = 1 at bit 0. SLT is op = 001 with b_invert = 1.
- No X propagation is allowed from unused inputs. less is ignored unless op = 001; cin is consumed only by the adder.
- The slice contains no combinational loop. The MSB-to-bit-0 less path is broken at the top level because set is computed from the adder, not from the result mux.

Optional Feature:
- Macro: ALU1_OVF_EN.
- When defined:
  - Adds output overflow (1 bit, combinational) = cin ^ carry_out, meaningful in the MSB slice only.
  - Adds output overflow_q, registered with the same en and reset rules; resets to 0.
- When undefined: neither port exists and behaviour is otherwise identical.

Decomposition:
- Package alu1_pkg holds:
  - op localparams OP_AND=3'b000, OP_SLT=3'b001, OP_OR=3'b010, OP_XOR=3'b011, OP_ADD=3'b100, OP_NOR=3'b101, OP_NAND=3'b110, OP_PASSA=3'b111;
  - an alu_op_t typedef.
- One sub-module, alu1_full_adder (aa, bb, cin -> sum, carry_out).
- The mux and registers stay in alu1_slice.

Test Plan:
- AND: a=1, b=1, op=000, en=1 -> result_q=1 after one edge. With b=0 -> 0. carry_out=1 combinationally for a=b=1, cin=0.
- ADD with carry: a=1, b=1, cin=1, op=100 -> set=1, carry_out=1, result_q=1 next edge. a=1, b=0, cin=0 -> result_q=1, carry_q=0.
- SUB/SLT: a=0, b=1, b_invert=1, cin=1, op=100 -> bb=0, sum=1, carry_out=0. op=001, less=1 -> result_q=1; less=0 -> 0.
- Invert/NOR: a=0, b=0, a_invert=1, op=000 -> 0. op=101, a_invert=0 -> 1. op=011, a=1, b=0 -> 1.
- Enable/reset: load result_q=1, then en=0 with changing inputs -> holds 1. Assert reset between edges -> result_q and carry_q drop to 0 immediately.
- ALU1_OVF_EN: cin=1, a=0, b=0 -> carry_out=0, overflow=1, overflow_q=1 next edge. cin=0, a=b=1 -> overflow=1.
